// File: rtl/fifo_stream_reader.sv
// Read-side master for the FIFO block: issues credit-limited reads and re-presents words as a valid/ready stream.
// Optional word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [31:0]           word_count
);

    localparam logic [1:0] LAST_SLOT = 2'd2;

    logic [1:0]            occ;
    logic                  inflight;
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic                  pop;
    logic [2:0]            credit_used;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == LAST_SLOT) ? 2'd0 : ptr + 2'd1;
    endfunction

    // A read is issued only if a buffer slot is already reserved for its data,
    // counting the word still in flight; m_ready never enters this path.
    always_comb begin
        credit_used = {1'b0, occ} + {2'b00, inflight};
        fifo_re     = ~reset & en & ~fifo_empty & (credit_used < 3'd3);
        m_valid     = (occ != 2'd0);
        pop         = m_valid & m_ready;
        m_data      = m_valid ? buf_mem[rd_ptr] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
        end else begin
            inflight <= fifo_re;
            if (inflight) wr_ptr <= next_ptr(wr_ptr);
            if (pop)      rd_ptr <= next_ptr(rd_ptr);
            occ <= 2'(({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop});
        end
    end

    // NOTE: the data store is deliberately not reset; occ gates m_valid/m_data, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (inflight && !reset) buf_mem[wr_ptr] <= fifo_data;
    end

`ifdef FIFO_READER_CNT_EN
    logic [31:0] word_count_q;

    always_ff @(posedge clk) begin
        if (reset)    word_count_q <= 32'd0;
        else if (pop) word_count_q <= word_count_q + 32'd1;
    end

    assign word_count = word_count_q;
`else
    assign word_count = 32'd0;
`endif

endmodule
